instr_feeder: RTL and testbench
===============================

# instr_feeder

Host-side instruction source for the `simple` core. It buffers 16-bit instruction words written by a loader into a FIFO, launches the core through its `exec` input, and presents each next instruction on `meirei` in step with the core's `phase` output. When the queue runs dry or a halt is requested, it issues the core's stop request and returns to idle. It is the driving end of the core's `exec`/`meirei`/`phase` interface.

## Interface
- DEPTH, 16, FIFO depth in words; power of two, ≥2
- AW, 4, log2(DEPTH)
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- wr_valid  in  1  loader offers `wr_data`
- wr_data  in  16  instruction word
- wr_ready  out  1  FIFO not full; a write happens when `wr_valid & wr_ready`
- start  in  1  level; starts a run when sampled high in IDLE
- halt_req  in  1  level; stops the run after the instruction in flight
- phase  in  3  core phase: 0 = idle/initial, 1..5 = execution phases
- exec  out  1  core start/stop request
- meirei  out  16  instruction presented to the core
- busy  out  1  high in every state except IDLE
- count  out  AW+1  FIFO occupancy, 0..DEPTH
- issued  out  16  instructions handed to the core since the last run start; wraps at 16'hFFFF→0

## Operation
- Core contract:
  - The core leaves phase 0 when it samples `exec`=1 while idle.
  - On the edge where `phase`==5, the core latches `meirei` as its next instruction.
  - `exec`=1 while the core is running makes it stop at the end of the current instruction and return to phase 0.
- FIFO:
  - Circular buffer with AW-bit read/write pointers and an (AW+1)-bit `count`.
  - A simultaneous push and pop leaves `count` unchanged.
  - When `count`==DEPTH, the write is refused (`wr_ready`=0).
  - A pop on an empty FIFO never occurs (guarded by state).
- `meirei` is a register. A pop loads the FIFO head into `meirei`.
- States:
  - IDLE: `exec`=0. If `start`=1 and `count`>0, pop into `meirei`, clear `issued`, go to LAUNCH. If `start`=1 and `count`=0, ignore and stay in IDLE.
  - LAUNCH: `exec`=1. Stay until `phase`≠0, then go to RUN with `exec`=0.
  - RUN: on each edge with `phase`==5:
    - Increment `issued`.
    - If `halt_req`=0 and `count`>0, pop the next word into `meirei`.
    - Otherwise go to STOP.
  - STOP: assert `exec`=1 for exactly one cycle on the first cycle where `phase`==1, then go to DRAIN.
  - DRAIN: `exec`=0. Wait until `phase`==0 has been sampled on 2 consecutive cycles, then go to IDLE.
- `halt_req` is only examined at the `phase`==5 edge in RUN. `start` is ignored outside IDLE.
- Writes are accepted in every state, including the same cycle as a pop.

## Timing
- Reset values:
  - state=IDLE, `exec`=0, `meirei`=16'h0000, `busy`=0, `count`=0, `issued`=0
  - pointers=0, `wr_ready`=1
- Reset is asserted asynchronously and released synchronously to `clk`. Reset mid-run empties the FIFO and drops `exec` immediately.
- Write-to-`count` latency: 1 cycle. `wr_ready` reflects the registered `count`.
- Start latency: `start` sampled in IDLE → `meirei` valid and `exec`=1 on the next cycle.
- Each instruction boundary updates `meirei` on the same edge the core latches the previous value. The core always captures the pre-edge word.
- The last FIFO entry is presented to the core and issued. STOP therefore stops the core after that last instruction completes.
- `exec` is never high for more than one cycle in STOP. In LAUNCH it stays high only while `phase`==0.

## Test plan
- Load 3 words (16'h1111, 16'h2222, 16'h3333) with the core model idle, then pulse `start` → `exec` is high until `phase`=1, and `meirei` sequences 1111, 2222, 3333 at successive `phase`==5 edges. At the third edge the block goes to STOP, one `exec` pulse occurs at the next `phase`==1, the block returns to IDLE, and `issued`=3.
- Write 17 words into DEPTH=16 → `wr_ready`=0 at `count`=16; the 17th word is not stored; `count` stays 16.
- Raise `halt_req` during instruction 2 of 5 → stop follows issue 2, `issued`=2, `count`=3 remains in the FIFO.
- Push and pop on the same `phase`==5 edge with `count`=4 → `count` stays 4, and FIFO order is preserved across pointer wrap (write 20 words over the run).
- Pulse `start` with an empty FIFO → `exec` stays 0 and `busy` stays 0.
- Assert `rst`=0 while in RUN → `exec`, `meirei`, `count`, and `issued` are all 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_feeder.sv
// rtl/instr_feeder.sv - instruction FIFO and launch/stop sequencer driving the simple core
//
// Buffers 16-bit instruction words from a loader, starts the core through
// exec, presents the next word on meirei at every phase==5 edge and stops the
// core once the queue is empty or a halt is requested.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   wr_valid/wr_data    loader write offer; accepted when wr_ready is high
//   wr_ready            FIFO not full
//   start               level; begins a run when seen in IDLE with words queued
//   halt_req            level; examined only at the phase==5 edge while running
//   phase               core phase (0 idle, 1..5 executing)
//   exec                core start/stop request
//   meirei              instruction word presented to the core
//   busy                high in every state except IDLE
//   count               FIFO occupancy, 0..DEPTH
//   issued              instructions handed to the core in the current run
module instr_feeder #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic [15:0]   wr_data,
    output logic          wr_ready,
    input  logic          start,
    input  logic          halt_req,
    input  logic [2:0]    phase,
    output logic          exec,
    output logic [15:0]   meirei,
    output logic          busy,
    output logic [AW:0]   count,
    output logic [15:0]   issued
);

    localparam logic [AW:0]   FULL    = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        STOP,
        DRAIN
    } state_t;

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          zero_seen;
    logic          push;
    logic          pop;
    logic          not_empty;
    logic          boundary;

    assign not_empty = (count != '0);
    assign wr_ready  = (count != FULL);
    assign push      = wr_valid & wr_ready;
    assign boundary  = (state == RUN) && (phase == 3'd5);

    // Pops happen only at run start or at an instruction boundary with work left,
    // so the FIFO can never be popped while empty.
    assign pop = ((state == IDLE) && start && not_empty) ||
                 (boundary && !halt_req && not_empty);

    // exec follows phase combinationally: in LAUNCH it must drop the moment the
    // core leaves phase 0 (otherwise the core would read it as a stop request),
    // and in STOP it is high only during the single phase==1 cycle.
    assign exec = ((state == LAUNCH) && (phase == 3'd0)) ||
                  ((state == STOP)   && (phase == 3'd1));
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            meirei    <= 16'h0000;
            issued    <= 16'h0000;
            zero_seen <= 1'b0;
        end else begin
            if (pop) begin
                meirei <= mem[rd_ptr];
            end
            case (state)
                IDLE: begin
                    if (start && not_empty) begin
                        issued <= 16'h0000;
                        state  <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (phase != 3'd0) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (phase == 3'd5) begin
                        issued <= issued + 16'd1;
                        if (halt_req || !not_empty) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (phase == 3'd1) begin
                        zero_seen <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The core is back at rest only after two consecutive phase==0 samples.
                    if (phase == 3'd0) begin
                        zero_seen <= 1'b1;
                        if (zero_seen) begin
                            state <= IDLE;
                        end
                    end else begin
                        zero_seen <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_feeder.sv
// tb/tb_instr_feeder.sv - scoreboard bench for instr_feeder with a behavioural core model
module tb_instr_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = 16'h0000;
    logic        wr_ready;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic [2:0]  phase;
    logic        exec;
    logic [15:0] meirei;
    logic        busy;
    logic [4:0]  count;
    logic [15:0] issued;

    logic        stop_req;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          accepted = 0;
    int          flushed = 0;
    int          total_latched = 0;
    int          pulses = 0;
    logic [15:0] exp_q[$];

    instr_feeder #(.DEPTH(16), .AW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .start    (start),
        .halt_req (halt_req),
        .phase    (phase),
        .exec     (exec),
        .meirei   (meirei),
        .busy     (busy),
        .count    (count),
        .issued   (issued)
    );

    always #5 clk = ~clk;

    // Behavioural core: leaves phase 0 on exec, cycles 1..5, takes meirei as its
    // next instruction at each phase-5 edge, and after an exec seen while running
    // finishes the current instruction and returns to phase 0.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase    <= 3'd0;
            stop_req <= 1'b0;
        end else begin
            if (phase != 3'd0 && exec) begin
                pulses <= pulses + 1;
            end
            if (phase == 3'd0) begin
                if (exec) phase <= 3'd1;
            end else if (phase != 3'd5) begin
                phase <= phase + 3'd1;
                if (exec) stop_req <= 1'b1;
            end else if (stop_req) begin
                phase    <= 3'd0;
                stop_req <= 1'b0;
            end else begin
                phase         <= 3'd1;
                total_latched <= total_latched + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every word the core takes must be the oldest accepted write.
    always @(negedge clk) begin
        if (rst && phase == 3'd5 && !stop_req) begin
            if (exp_q.size() == 0) begin
                chk("latch_unexpected", 32'(meirei), 32'hFFFF_FFFF);
            end else begin
                chk("latched_word", 32'(meirei), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic int occ();
        return accepted - total_latched - flushed;
    endfunction

    // Called just after a falling edge; holds the offer across one rising edge.
    task automatic do_write(input logic [15:0] d);
        bit er;
        er = (occ() < 16);
        wr_valid = 1'b1;
        wr_data  = d;
        chk("wr_ready", 32'(wr_ready), 32'(er));
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        if (er) begin
            exp_q.push_back(d);
            accepted++;
        end
    endtask

    task automatic load(input int n, input logic [15:0] base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            do_write(rnd ? 16'($urandom) : base + 16'(i));
        end
    endtask

    // mode 0: plain run; 1: random writes and halts; 2: halt once arg words taken;
    // 3: write one word at each phase-5 edge until arg words have been added.
    task automatic do_run(input int mode, input int arg);
        int  bl;
        int  bp;
        int  fed;
        bit  done;
        bl   = total_latched;
        bp   = pulses;
        fed  = 0;
        done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("exec_launch", 32'(exec), 32'd1);
        chk("busy_launch", 32'(busy), 32'd1);
        chk("meirei_launch", 32'(meirei), 32'(exp_q[0]));
        fork
            begin
                for (int k = 0; k < 3000 && busy; k++) @(negedge clk);
                chk("run_timeout", 32'(busy), 32'd0);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    if (!done) begin
                        if (mode == 1) begin
                            halt_req = ($urandom_range(0, 9) == 0);
                            if ($urandom_range(0, 2) == 0 && occ() < 16) do_write(16'($urandom));
                        end else if (mode == 2) begin
                            if (total_latched - bl >= arg) halt_req = 1'b1;
                        end else if (mode == 3) begin
                            if (phase == 3'd5 && !stop_req && fed < arg) begin
                                do_write(16'($urandom));
                                fed++;
                                chk("pushpop_count", 32'(count), 32'd4);
                            end
                        end
                    end
                end
            end
        join
        halt_req = 1'b0;
        chk("issued", 32'(issued), 32'(total_latched - bl));
        chk("stop_pulses", 32'(pulses - bp), 32'd1);
        chk("count_idle", 32'(count), 32'(occ()));
        chk("exec_idle", 32'(exec), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_exec", 32'(exec), 32'd0);
        chk("rst_meirei", 32'(meirei), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_issued", 32'(issued), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        rst = 1'b1;

        // Start with nothing queued is ignored.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("empty_exec", 32'(exec), 32'd0);
            chk("empty_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end

        // Three directed words.
        @(negedge clk); do_write(16'h1111);
        @(negedge clk); do_write(16'h2222);
        @(negedge clk); do_write(16'h3333);
        do_run(0, 0);
        chk("three_issued", 32'(issued), 32'd3);

        // Fill past full: 17th word refused.
        load(17, 16'hA000, 1'b0);
        chk("full_count", 32'(count), 32'd16);
        chk("full_ready", 32'(wr_ready), 32'd0);
        do_run(0, 0);
        chk("full_issued", 32'(issued), 32'd16);

        // Halt during instruction 2 of 5.
        load(5, 16'hB000, 1'b0);
        do_run(2, 1);
        chk("halt_issued", 32'(issued), 32'd2);
        chk("halt_count", 32'(count), 32'd3);
        do_run(0, 0);
        chk("resume_issued", 32'(issued), 32'd3);

        // Simultaneous push/pop at count 4, 20 words total over the run.
        load(5, 16'hC000, 1'b0);
        do_run(3, 15);
        chk("pushpop_issued", 32'(issued), 32'd20);

        // Random traffic rounds.
        for (int r = 0; r < 8; r++) begin
            load($urandom_range(1, 8), 16'h0000, 1'b1);
            do_run(1, 0);
        end
        if (occ() > 0) do_run(0, 0);
        chk("drained_count", 32'(count), 32'd0);

        // Asynchronous reset in the middle of a run.
        load(4, 16'hD000, 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 50 && phase != 3'd3; k++) @(negedge clk);
        chk("reach_run_phase3", 32'(phase), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_exec", 32'(exec), 32'd0);
        chk("arst_meirei", 32'(meirei), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_issued", 32'(issued), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        flushed = accepted - total_latched;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;

        // Recovery after reset.
        load(6, 16'h0000, 1'b1);
        do_run(1, 0);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
